seg7_scan_driver: RTL

- Consumes the 16-bit test_value produced by the processor top level and shows it as 4 hex digits on a multiplexed 7-segment display.
- Runs a refresh prescaler and a one-hot digit scanner, with optional leading-zero blanking.
- Latches the value once per frame so the displayed digits never tear.
- A decimal-point flag marks frames whose value changed.

---
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit hex scanner for a multiplexed 7-segment display with per-frame value latching.
// Outputs are a combinational decode of registered state; a new value appears at the next frame boundary.
module seg7_scan_driver #(
  parameter int CLK_DIV        = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt;
  logic [1:0]      idx;
  logic [15:0]     shadow;
  logic            lz;
  logic            pending;
  logic            newFlag;

  logic            tick;
  logic            frameLoad;

  assign tick      = (cnt == CntMax);
  assign frameLoad = pending | (tick & (idx == 2'd3));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      lz      <= 1'b0;
      newFlag <= 1'b0;
      pending <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + CntW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      // Latching only at frame boundaries keeps all four digits from one value.
      if (frameLoad) begin
        shadow  <= value;
        lz      <= blank_lz;
        newFlag <= (value != shadow);
        pending <= 1'b0;
      end
    end
  end

  logic [3:0] nib;
  logic [6:0] codeLow;
  logic       blankDigit;
  logic [6:0] segLow;
  logic [3:0] anLow;
  logic       dpLow;

  always_comb begin
    nib = shadow[{idx, 2'b00} +: 4];
    case (nib)
      4'h0:    codeLow = 7'h40;
      4'h1:    codeLow = 7'h79;
      4'h2:    codeLow = 7'h24;
      4'h3:    codeLow = 7'h30;
      4'h4:    codeLow = 7'h19;
      4'h5:    codeLow = 7'h12;
      4'h6:    codeLow = 7'h02;
      4'h7:    codeLow = 7'h78;
      4'h8:    codeLow = 7'h00;
      4'h9:    codeLow = 7'h10;
      4'hA:    codeLow = 7'h08;
      4'hB:    codeLow = 7'h03;
      4'hC:    codeLow = 7'h46;
      4'hD:    codeLow = 7'h21;
      4'hE:    codeLow = 7'h06;
      default: codeLow = 7'h0E;
    endcase
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    case (idx)
      2'd3:    blankDigit = (shadow[15:12] == 4'h0);
      2'd2:    blankDigit = (shadow[15:8] == 8'h00);
      2'd1:    blankDigit = (shadow[15:4] == 12'h000);
      default: blankDigit = 1'b0;
    endcase
  end

  always_comb begin
    segLow = (lz && blankDigit) ? 7'h7F : codeLow;
    anLow  = ~(4'b0001 << idx);
    dpLow  = ~((idx == 2'd0) && newFlag);
  end

  always_comb begin
    if (SEG_ACTIVE_LOW) begin
      an  = anLow;
      seg = segLow;
      dp  = dpLow;
    end else begin
      an  = ~anLow;
      seg = ~segLow;
      dp  = ~dpLow;
    end
  end

endmodule
